// File: rtl/fle_ccff_pkg.sv
// Shared types and defaults for the FLE configuration-chain loader.
package fle_ccff_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ccff_state_e;

    localparam int unsigned NUM_CHAINS_DEF = 4;
    localparam int unsigned CHAIN_LEN_DEF  = 20;

    // beat_cnt must be able to hold CHAIN_LEN itself, not just CHAIN_LEN-1
    function automatic int unsigned beat_cnt_width(input int unsigned chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/fle_ccff_rb_capture.sv
// Captures the chain tails on every shift strobe and presents them one cycle later.
module fle_ccff_rb_capture #(
    parameter int unsigned NUM_CHAINS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [NUM_CHAINS-1:0] i_tail,
    output logic                  o_valid,
    output logic [NUM_CHAINS-1:0] o_data
);

    logic                  r_valid;
    logic [NUM_CHAINS-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_en;
            if (i_en) begin
                r_data <= i_tail;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fle_ccff_loader.sv
// Streams CHAIN_LEN beats into NUM_CHAINS parallel configuration chains.
// Define CCFF_READBACK_EN to capture the previous chain contents on rb_valid/rb_data.
module fle_ccff_loader
    import fle_ccff_pkg::*;
#(
    parameter int unsigned  NUM_CHAINS = NUM_CHAINS_DEF,
    parameter int unsigned  CHAIN_LEN  = CHAIN_LEN_DEF,
    localparam int unsigned CNT_W      = beat_cnt_width(CHAIN_LEN)
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_valid,
    input  logic [NUM_CHAINS-1:0] cfg_data,
    output logic                  cfg_ready,
    output logic [NUM_CHAINS-1:0] ccff_head,
    output logic                  ccff_en,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      beat_cnt,
    output logic                  rb_valid,
    output logic [NUM_CHAINS-1:0] rb_data
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

    ccff_state_e           r_state;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [NUM_CHAINS-1:0] r_head;
    logic                  r_en;
    logic                  r_done;
    logic                  w_accept;

    assign cfg_ready = (r_state == LOAD) && (r_beat_cnt < LEN_C);
    // A beat coinciding with abort is dropped
    assign w_accept  = cfg_valid && cfg_ready && !abort;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_head     <= '0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_en   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_state    <= LOAD;
                        r_beat_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (r_beat_cnt == LEN_C) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else if (w_accept) begin
                        r_head     <= cfg_data;
                        r_en       <= 1'b1;
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ccff_head = r_head;
    assign ccff_en   = r_en;
    assign done      = r_done;
    assign busy      = (r_state == LOAD);
    assign beat_cnt  = r_beat_cnt;

`ifdef CCFF_READBACK_EN
    fle_ccff_rb_capture #(
        .NUM_CHAINS (NUM_CHAINS)
    ) u_rb_capture (
        .i_clk   (prog_clk),
        .i_rst   (pReset),
        .i_en    (r_en),
        .i_tail  (ccff_tail),
        .o_valid (rb_valid),
        .o_data  (rb_data)
    );
`else
    logic w_unused_tail;
    assign w_unused_tail = ^ccff_tail;
    assign rb_valid      = 1'b0;
    assign rb_data       = '0;
`endif

endmodule

// File: tb/tb_fle_ccff_loader.sv
// Scoreboard bench for fle_ccff_loader: driver predicts accepted beats, monitor checks strobes.
module tb_fle_ccff_loader;

    localparam int NC  = 4;
    localparam int LEN = 20;
    localparam int CW  = $clog2(LEN + 1);

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          start, abort, cfg_valid;
    logic [NC-1:0] cfg_data;
    logic          cfg_ready;
    logic [NC-1:0] ccff_head;
    logic          ccff_en;
    logic [NC-1:0] ccff_tail;
    logic          busy, done;
    logic [CW-1:0] beat_cnt;
    logic          rb_valid;
    logic [NC-1:0] rb_data;

    fle_ccff_loader #(
        .NUM_CHAINS (NC),
        .CHAIN_LEN  (LEN)
    ) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .start     (start),
        .abort     (abort),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .ccff_head (ccff_head),
        .ccff_en   (ccff_en),
        .ccff_tail (ccff_tail),
        .busy      (busy),
        .done      (done),
        .beat_cnt  (beat_cnt),
        .rb_valid  (rb_valid),
        .rb_data   (rb_data)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic [NC-1:0] data;
        int            idx;
        bit            last;
    } beat_t;

    beat_t         sb_q[$];
    int            errors = 0;
    int            checks = 0;
    int            strobes = 0;
    int            dones = 0;
    int            rb5_hits = 0;
    bit            m_load = 0;
    int            m_cnt = 0;
    logic [NC-1:0] last_head = '0;
    bit            exp_done_next = 0;
    bit            prev_en = 0;
    logic [NC-1:0] tail_snap = '0;
    logic          preload_req;

    // Behavioural model of the external chains: a plain shift register per chain
    logic [NC-1:0] chain [LEN];
    assign ccff_tail = chain[LEN-1];
    always @(posedge prog_clk) begin
        if (preload_req) begin
            for (int i = 0; i < LEN; i++) chain[i] <= NC'(5);
        end else if (ccff_en) begin
            for (int i = LEN - 1; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= ccff_head;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected beat per observed strobe
    initial begin
        beat_t it;
        forever begin
            @(negedge prog_clk);
            if (pReset) begin
                exp_done_next = 0;
                prev_en       = 0;
            end else begin
                if (done) dones++;
                if (done || exp_done_next) check("done_pulse", 32'(done), 32'(exp_done_next));
`ifdef CCFF_READBACK_EN
                if (prev_en) begin
                    check("rb_valid", 32'(rb_valid), 32'd1);
                    check("rb_data", 32'(rb_data), 32'(tail_snap));
                    if (rb_valid && rb_data == NC'(5)) rb5_hits++;
                end else if (rb_valid) begin
                    check("rb_valid_idle", 32'(rb_valid), 32'd0);
                end
`else
                if (ccff_en) check("rb_tied", 32'({rb_valid, rb_data}), 32'd0);
`endif
                if (ccff_en) begin
                    strobes++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_strobe", 32'(ccff_en), 32'd0);
                        exp_done_next = 0;
                    end else begin
                        it = sb_q.pop_front();
                        check("ccff_head", 32'(ccff_head), 32'(it.data));
                        check("beat_cnt_strobe", 32'(beat_cnt), 32'(it.idx));
                        last_head     = it.data;
                        exp_done_next = it.last;
                    end
                    tail_snap = ccff_tail;
                end else begin
                    check("head_hold", 32'(ccff_head), 32'(last_head));
                    exp_done_next = 0;
                end
                prev_en = ccff_en;
            end
        end
    end

    // One cycle of stimulus; the model decides whether the beat will be taken
    task automatic drive(input logic v, input logic [NC-1:0] d, input logic st, input logic ab);
        bit    exp_rdy;
        beat_t it;
        @(negedge prog_clk);
        #1;
        exp_rdy = m_load && (m_cnt < LEN);
        check("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
        cfg_valid = v;
        cfg_data  = d;
        start     = st;
        abort     = ab;
        if (exp_rdy && v && !ab) begin
            m_cnt++;
            it.data = d;
            it.idx  = m_cnt;
            it.last = (m_cnt == LEN);
            sb_q.push_back(it);
        end
        if (ab) m_load = 0;
        else if (st && !m_load) begin
            m_load = 1;
            m_cnt  = 0;
        end
    endtask

    // mode 0: back-to-back fixed data; 1: valid every other cycle; 2: random valid/data/start
    task automatic run_load(input int mode, input logic [NC-1:0] fixed);
        int            s0, d0, guard;
        logic          v, st;
        logic [NC-1:0] d;
        s0 = strobes;
        d0 = dones;
        drive(1'b0, '0, 1'b1, 1'b0);
        guard = 0;
        while (m_cnt < LEN && guard < 400) begin
            v  = (mode == 0) ? 1'b1 : (mode == 1) ? guard[0] : 1'($urandom_range(0, 1));
            d  = (mode == 2) ? NC'($urandom) : fixed;
            st = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            drive(v, d, st, 1'b0);
            guard++;
        end
        if (guard >= 400) check("load_timeout", 32'(m_cnt), 32'(LEN));
        repeat (4) drive(1'b0, '0, 1'b0, 1'b0);
        m_load = 0;
        check("beat_cnt_final", 32'(beat_cnt), 32'(LEN));
        check("busy_after", 32'(busy), 32'd0);
        check("strobes_per_load", 32'(strobes - s0), 32'(LEN));
        check("done_count", 32'(dones - d0), 32'd1);
    endtask

    initial begin
        int d0;
        pReset      = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data    = '0;
        preload_req = 1'b1;
        repeat (3) @(posedge prog_clk);
        #1;
        check("rst_head", 32'(ccff_head), 32'd0);
        check("rst_en", 32'(ccff_en), 32'd0);
        check("rst_cnt", 32'(beat_cnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_rb", 32'({rb_valid, rb_data}), 32'd0);
        @(negedge prog_clk);
        #3;
        pReset      = 1'b0;
        preload_req = 1'b0;

        // Full back-to-back load
        run_load(0, 4'hA);
        // Bubbles
        run_load(1, 4'h3);

        // Abort after 7 beats with a beat presented alongside abort
        d0 = dones;
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (7) drive(1'b1, 4'hA, 1'b0, 1'b0);
        drive(1'b1, 4'h6, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cnt", 32'(beat_cnt), 32'd7);
        repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
        check("abort_no_done", 32'(dones - d0), 32'd0);

        // start together with abort in IDLE is ignored
        drive(1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("prio_busy", 32'(busy), 32'd0);
        check("prio_cnt", 32'(beat_cnt), 32'd7);

        // Randomized loads, including start pulses during LOAD
        repeat (3) run_load(2, '0);

        // Reset at beat 12
        d0 = dones;
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (12) drive(1'b1, NC'($urandom), 1'b0, 1'b0);
        @(negedge prog_clk);
        #3;
        pReset = 1'b1;
        #1;
        check("mid_rst_head", 32'(ccff_head), 32'd0);
        check("mid_rst_en", 32'(ccff_en), 32'd0);
        check("mid_rst_cnt", 32'(beat_cnt), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rb", 32'({rb_valid, rb_data}), 32'd0);
        sb_q.delete();
        m_load    = 0;
        m_cnt     = 0;
        last_head = '0;
        cfg_valid = 1'b0;
        @(negedge prog_clk);
        #3;
        pReset = 1'b0;
        repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
        check("mid_rst_no_done", 32'(dones - d0), 32'd0);
        run_load(0, 4'h9);

`ifdef CCFF_READBACK_EN
        preload_req = 1'b1;
        @(negedge prog_clk);
        @(negedge prog_clk);
        #3;
        preload_req = 1'b0;
        rb5_hits    = 0;
        run_load(0, 4'hC);
        check("rb_hits_5", 32'(rb5_hits), 32'(LEN));
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
